// File: rtl/shift_register_if.sv
// Bus bundle between the SPI controller (master) and the datapath shift register (slave).
// The signal names match the original flat ports, so existing connections map across by name.
interface shift_register_if #(
    parameter int unsigned width = 8
);
    logic             peripheralClkEdge;
    logic             parallelLoad;
    logic [width-1:0] parallelDataIn;
    logic             serialDataIn;
    logic [width-1:0] parallelDataOut;
    logic             serialDataOut;

    modport master (
        output peripheralClkEdge,
        output parallelLoad,
        output parallelDataIn,
        output serialDataIn,
        input  parallelDataOut,
        input  serialDataOut
    );

    modport slave (
        input  peripheralClkEdge,
        input  parallelLoad,
        input  parallelDataIn,
        input  serialDataIn,
        output parallelDataOut,
        output serialDataOut
    );
endinterface

// File: rtl/shift_register.sv
// SPI datapath shift register: serial-in/parallel-out for receive, parallel-in/serial-out for transmit.
// A parallel load takes priority over a shift; both outputs come directly from the register.
module shift_register #(
    parameter int unsigned width = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    shift_register_if.slave    bus
);

    logic [width-1:0] r_shiftregistermem;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shiftregistermem <= '0;
        end else if (bus.parallelLoad) begin
            r_shiftregistermem <= bus.parallelDataIn;
        end else if (bus.peripheralClkEdge) begin
            r_shiftregistermem <= {r_shiftregistermem[width-2:0], bus.serialDataIn};
        end
    end

    assign bus.parallelDataOut = r_shiftregistermem;
    assign bus.serialDataOut   = r_shiftregistermem[width-1];

endmodule

// File: tb/tb_shift_register.sv
// Self-checking bench for shift_register: expected words are queued when stimulus is driven
// and compared after the clock edge that applies it.
module tb_shift_register;
    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;

    shift_register_if #(.width(W)) bus ();

    shift_register #(.width(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [W-1:0] model;
    bit           model_valid = 1'b0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: drive, verify no input-to-output path, queue expectation, check result.
    task automatic step(input logic rst, input logic ld, input logic pe,
                        input logic si, input logic [W-1:0] pdi, input string tag);
        logic [W-1:0] e;
        @(negedge clk);
        rst_n                 = rst;
        bus.parallelLoad      = ld;
        bus.peripheralClkEdge = pe;
        bus.serialDataIn      = si;
        bus.parallelDataIn    = pdi;
        #1;
        if (model_valid) check({tag, "_hold_pre_edge"}, 64'(bus.parallelDataOut), 64'(model));
        if (!rst)      model = '0;
        else if (ld)   model = pdi;
        else if (pe)   model = {model[W-2:0], si};
        model_valid = model_valid | !rst | ld;
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_pdo"}, 64'(bus.parallelDataOut), 64'(e));
            check({tag, "_sdo"}, 64'(bus.serialDataOut), 64'(e[W-1]));
        end
    endtask

    logic [W-1:0] rnd;
    logic [6:0]   piso_exp;

    initial begin
        rst_n                 = 1'b1;
        bus.parallelLoad      = 1'b0;
        bus.peripheralClkEdge = 1'b0;
        bus.serialDataIn      = 1'b0;
        bus.parallelDataIn    = '0;
        model                 = '0;

        // arbitrary contents, then reset with load and strobe active
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, "preload");
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, "reset");
        check("reset_pdo_const", 64'(bus.parallelDataOut), 64'h00);
        check("reset_sdo_const", 64'(bus.serialDataOut), 64'h0);

        // serial fill 0,1,0,1,...
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'(i % 2), 8'hFF, "fill");
        check("fill_const", 64'(bus.parallelDataOut), 64'h55);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, "fill9");
        check("fill9_const", 64'(bus.parallelDataOut), 64'hAB);

        // load holds against strobes while parallelLoad stays high
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, "load0");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'(i % 2), 8'h00, "load_hold");
        check("load_hold_const", 64'(bus.parallelDataOut), 64'h00);

        // parallel-in / serial-out
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h55, "piso_load");
        check("piso_msb_const", 64'(bus.serialDataOut), 64'h0);
        piso_exp = 7'b1010101;
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, "piso_shift");
            check("piso_bit_const", 64'(bus.serialDataOut), 64'(piso_exp[i]));
        end
        check("piso_end_const", 64'(bus.parallelDataOut), 64'h80);

        // parallelDataIn changes with load low and no strobes
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 8'hD5, "gate");
        check("gate_const", 64'(bus.parallelDataOut), 64'h80);

        // load wins over simultaneous strobe, then idle hold
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, "prio");
        check("prio_const", 64'(bus.parallelDataOut), 64'h3C);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'hC3, "idle");
        check("idle_const", 64'(bus.parallelDataOut), 64'h3C);

        // held strobe shifts every edge, then a mid-shift reset
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, "held_strobe");
        check("held_strobe_const", 64'(bus.parallelDataOut), 64'hCF);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, "reset_mid");

        // random mix
        for (int i = 0; i < 40; i++) begin
            rnd = 8'($urandom);
            step(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0),
                 1'($urandom), 1'($urandom), rnd, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
